// File: rtl/pcie_dma_sched_pkg.sv
// Shared types for the PCIe DMA scheduler: FSM states, the register record
// with its reset value, default sizing and the round-robin pointer helper.
package pcie_dma_sched_pkg;

    localparam int REQ_MAX     = 4;
    localparam int REQ_NUM_DEF = 4;
    localparam int TIMEOUT_DEF = 4096;
    localparam int WDOG_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Vectors are sized for the largest configuration; only the low REQ_NUM bits are used.
    typedef struct packed {
        state_e               state;
        logic [1:0]           rr_ptr;
        logic [1:0]           owner;
        logic [31:0]          addr;
        logic [11:0]          len;
        logic                 write;
        logic                 dma_valid;
        logic [WDOG_W-1:0]    wdog;
        logic [REQ_MAX-1:0]   ready;
        logic [REQ_MAX-1:0]   done;
        logic [REQ_MAX-1:0]   err;
    } regs_t;

    localparam regs_t REGS_RST = '{
        state:     ST_IDLE,
        rr_ptr:    2'd0,
        owner:     2'd0,
        addr:      32'd0,
        len:       12'd0,
        write:     1'b0,
        dma_valid: 1'b0,
        wdog:      16'd0,
        ready:     4'd0,
        done:      4'd0,
        err:       4'd0
    };

    function automatic logic [1:0] next_ptr(input logic [1:0] cur, input int req_num);
        return (int'(cur) >= req_num - 1) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/pcie_dma_sched_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// i_ptr, wrapping modulo N. Outputs a one-hot grant and its index.
module pcie_dma_sched_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [1:0]   i_ptr,
    output logic [N-1:0] o_grant,
    output logic [1:0]   o_idx,
    output logic         o_any
);

    int w_dist;
    int w_best;

    // NOTE: every output and temporary gets a default before any branch so no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_idx   = 2'd0;
        o_any   = 1'b0;
        w_best  = N;
        w_dist  = 0;
        // Distance from the pointer decides priority; the smallest distance wins.
        for (int k = 0; k < N; k++) begin
            w_dist = k - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N;
            end
            if (i_req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = 2'(k);
                o_any  = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            o_grant[k] = o_any && (o_idx == 2'(k));
        end
    end

endmodule

// File: rtl/pcie_dma_sched.sv
// Round-robin scheduler sharing one PCIe DMA engine between up to four
// requesters: grant, forward the command, then wait for done or watchdog.
module pcie_dma_sched
    import pcie_dma_sched_pkg::*;
#(
    parameter bit async_reset = 1'b1,
    parameter int REQ_NUM     = REQ_NUM_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_link_up,
    input  logic [REQ_NUM-1:0]    i_req_valid,
    output logic [REQ_NUM-1:0]    o_req_ready,
    input  logic [REQ_NUM*32-1:0] i_req_addr,
    input  logic [REQ_NUM*12-1:0] i_req_len,
    input  logic [REQ_NUM-1:0]    i_req_write,
    output logic                  o_dma_valid,
    input  logic                  i_dma_ready,
    output logic [31:0]           o_dma_addr,
    output logic [11:0]           o_dma_len,
    output logic                  o_dma_write,
    input  logic                  i_dma_done,
    output logic [REQ_NUM-1:0]    o_done,
    output logic [REQ_NUM-1:0]    o_err,
    output logic [1:0]            o_owner,
    output logic                  o_busy
);

    regs_t              r_cur;
    regs_t              w_nxt;
    logic [REQ_NUM-1:0] w_grant;
    logic [1:0]         w_idx;
    logic               w_any;

    pcie_dma_sched_rr_arbiter #(
        .N (REQ_NUM)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_cur.rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_nxt       = r_cur;
        w_nxt.ready = '0;
        w_nxt.done  = '0;
        w_nxt.err   = '0;
        case (r_cur.state)
            ST_IDLE: begin
                if (i_link_up && w_any) begin
                    w_nxt.state = ST_ISSUE;
                    w_nxt.ready = REQ_MAX'(w_grant);
                    w_nxt.owner = w_idx;
                    for (int k = 0; k < REQ_NUM; k++) begin
                        if (w_grant[k]) begin
                            w_nxt.addr  = i_req_addr[32*k +: 32];
                            w_nxt.len   = i_req_len[12*k +: 12];
                            w_nxt.write = i_req_write[k];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                // The first ISSUE cycle carries o_req_ready; the engine sees valid one cycle later.
                if (!r_cur.dma_valid) begin
                    w_nxt.dma_valid = 1'b1;
                end else if (i_dma_ready) begin
                    w_nxt.dma_valid = 1'b0;
                    w_nxt.wdog      = '0;
                    w_nxt.state     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion is checked first so a done on the timeout cycle suppresses the error.
                if (i_dma_done) begin
                    w_nxt.done[r_cur.owner] = 1'b1;
                    w_nxt.rr_ptr            = next_ptr(r_cur.owner, REQ_NUM);
                    w_nxt.state             = ST_IDLE;
                end else if (r_cur.wdog == WDOG_W'(TIMEOUT - 1)) begin
                    w_nxt.err[r_cur.owner]  = 1'b1;
                    w_nxt.rr_ptr            = next_ptr(r_cur.owner, REQ_NUM);
                    w_nxt.state             = ST_IDLE;
                end else if (r_cur.wdog != '1) begin
                    w_nxt.wdog = r_cur.wdog + 16'd1;
                end
            end
            default: begin
                w_nxt = REGS_RST;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    generate
        if (async_reset) begin : g_async_rst
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    r_cur <= REGS_RST;
                end else begin
                    r_cur <= w_nxt;
                end
            end
        end else begin : g_sync_rst
            always_ff @(posedge i_clk) begin
                if (!i_nrst) begin
                    r_cur <= REGS_RST;
                end else begin
                    r_cur <= w_nxt;
                end
            end
        end
    endgenerate

    assign o_req_ready = r_cur.ready[REQ_NUM-1:0];
    assign o_done      = r_cur.done[REQ_NUM-1:0];
    assign o_err       = r_cur.err[REQ_NUM-1:0];
    assign o_dma_valid = r_cur.dma_valid;
    assign o_dma_addr  = r_cur.addr;
    assign o_dma_len   = r_cur.len;
    assign o_dma_write = r_cur.write;
    assign o_owner     = r_cur.owner;
    assign o_busy      = (r_cur.state != ST_IDLE);

endmodule

// File: doc/pcie_dma_sched.md
# pcie_dma_sched

Round-robin scheduler that shares the single PCIe DMA engine between up to four on-chip requesters. It accepts transfer commands (address, length, direction) from each requester, grants exactly one at a time, forwards the command to the engine, and tracks completion with a watchdog. It sits between the SoC-side DMA clients and the PCIe DMA engine, next to the PCIe APB control block that reports DMA state.

## Interface
- async_reset, 1'b1: reset style selector; this block is always instantiated with 1 (asynchronous).
- REQ_NUM, 4: number of requesters, 2..4.
- TIMEOUT, 4096: watchdog limit in cycles, 16..65535.
- i_clk  in  1  single clock; all logic on its rising edge.
- i_nrst  in  1  reset, asynchronous, active LOW.
- i_link_up  in  1  PCIe link usable; gates new grants.
- i_req_valid  in  REQ_NUM  per-requester command valid.
- o_req_ready  out  REQ_NUM  per-requester command accepted (one-hot or zero).
- i_req_addr  in  REQ_NUM*32  per-requester host address, slice k = bits [32k+31:32k].
- i_req_len  in  REQ_NUM*12  per-requester length in dwords, 0 encodes 4096.
- i_req_write  in  REQ_NUM  1 = device-to-host.
- o_dma_valid  out  1  command to engine valid.
- i_dma_ready  in  1  engine accepts command.
- o_dma_addr  out  32  granted address.
- o_dma_len  out  12  granted length.
- o_dma_write  out  1  granted direction.
- i_dma_done  in  1  engine completion pulse.
- o_done  out  REQ_NUM  one-cycle completion pulse to the owning requester.
- o_err  out  REQ_NUM  one-cycle timeout pulse to the owning requester.
- o_owner  out  2  index of current/last granted requester.
- o_busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if i_link_up and any i_req_valid, pick the first valid index starting at rr_ptr, wrapping modulo REQ_NUM; assert o_req_ready[k] for that one cycle, latch addr/len/write into registers, o_owner<=k, go ISSUE. No link or no request: stay.
- ISSUE: o_dma_valid=1 with latched fields, held stable until i_dma_ready. On valid&ready go WAIT, clear watchdog.
- WAIT: watchdog increments each cycle. i_dma_done -> o_done[owner] pulse, rr_ptr<=owner+1 (wrap), IDLE. Watchdog reaches TIMEOUT-1 without done -> o_err[owner] pulse, rr_ptr advanced identically, IDLE.
- i_dma_done in the same cycle as the timeout compare: done wins, no o_err.
- i_dma_done outside WAIT is ignored.
- i_link_up falling in ISSUE or WAIT does not abort; it only blocks the next grant.
- Requester index >= REQ_NUM never granted; unused input bits ignored.
- Watchdog is 16 bits, saturates, never wraps.

## Timing
- Reset values: state IDLE, rr_ptr 0, o_owner 0, all outputs 0, latched fields 0, watchdog 0.
- Asynchronous reset mid-transfer returns to IDLE immediately; any in-flight engine command is abandoned (engine resets on the same net).
- o_req_ready is registered: asserted the cycle after the qualifying i_req_valid is sampled in IDLE; requester holds valid and fields until it sees ready.
- o_dma_valid rises the cycle after o_req_ready.
- o_done/o_err rise the cycle after i_dma_done or timeout; IDLE re-arbitration the next cycle, so minimum back-to-back grant spacing is 4 cycles with zero-latency engine.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- pcie_dma_sched_pkg: state enum, register record (state, rr_ptr, owner, addr, len, write, wdog, ready/done/err vectors), its reset constant, and default REQ_NUM/TIMEOUT constants.
- Sub-module rr_arbiter (REQ_NUM request vector, pointer in, one-hot grant and index out, purely combinational) instantiated once.
- Single comb process plus async-reset always_ff, matching team style.

## Test plan
- Single request: req 1 addr 0x8000_1000 len 0x040 write 1 -> ready[1] once, dma fields match, done[1] one cycle after i_dma_done, rr_ptr=2.
- Fairness: all four valid continuously, engine done 5 cycles after accept -> grant order 0,1,2,3,0 with equal counts over 40 grants.
- Timeout: TIMEOUT=16, no i_dma_done -> o_err[owner] exactly 16 cycles after accept, no o_done, next requester granted.
- Done/timeout collision: i_dma_done on the TIMEOUT-1 cycle -> o_done only.
- Link gating: i_link_up=0 with requests pending -> no o_req_ready for 100 cycles; raise link -> grant within 2 cycles; drop link in WAIT -> transfer still completes.
- Reset mid-WAIT: assert i_nrst low -> all outputs 0 immediately, state IDLE, rr_ptr 0 after release.
